// File: rtl/output_mems.sv
// Result buffer: collects one M x N matrix written in row-major order, then
// streams it out over AXI-Stream in address order before taking the next one.
module output_mems #(
    parameter int OUTW = 24,
    parameter int M    = 7,
    parameter int N    = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OUTW-1:0] wr_data,
    input  logic            wr_valid,
    output logic            wr_ready,
    output logic            results_stored,
    output logic [OUTW-1:0] AXIS_TDATA,
    output logic            AXIS_TVALID,
    input  logic            AXIS_TREADY,
    output logic            AXIS_TLAST
);
    localparam int DEPTH     = M * N;
    localparam int ADDR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t          state;
    state_t          state_next;
    logic [OUTW-1:0] mem [DEPTH];
    logic [OUTW-1:0] rd_data;
    logic [ADDR_BITS-1:0] wr_cnt;
    logic [ADDR_BITS-1:0] rd_addr;
    logic            rd_done;
    logic            rd_en;
    logic            wr_en;
    logic            s1_valid;
    logic            s1_last;
    logic            out_valid;
    logic            out_last;
    logic [OUTW-1:0] out_data;
    logic            out_load;
    logic            out_fire;
    logic            stored_q;

    assign wr_ready       = (state == FILL) && !reset;
    assign wr_en          = wr_valid && wr_ready;
    assign out_fire       = out_valid && AXIS_TREADY;
    assign out_load       = s1_valid && (!out_valid || AXIS_TREADY);
    // A read is issued only when the memory output register will be free by
    // the next edge, so it doubles as the prefetch stage and no skid is needed.
    assign rd_en          = (state == DRAIN) && !rd_done && (!s1_valid || out_load);

    assign AXIS_TDATA     = out_data;
    assign AXIS_TVALID    = out_valid;
    assign AXIS_TLAST     = out_last;
    assign results_stored = stored_q;

    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                if (wr_en && (wr_cnt == LAST_ADDR)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire && out_last) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Single-port storage: writes only happen in FILL and reads only in DRAIN.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_cnt] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FILL;
            wr_cnt    <= '0;
            rd_addr   <= '0;
            rd_done   <= 1'b0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            stored_q  <= 1'b0;
        end else begin
            state    <= state_next;
            stored_q <= wr_en && (wr_cnt == LAST_ADDR);

            if (wr_en) begin
                wr_cnt <= (wr_cnt == LAST_ADDR) ? '0 : wr_cnt + 1'b1;
            end

            if (rd_en) begin
                s1_last <= (rd_addr == LAST_ADDR);
                if (rd_addr == LAST_ADDR) begin
                    rd_addr <= '0;
                    rd_done <= 1'b1;
                end else begin
                    rd_addr <= rd_addr + 1'b1;
                end
            end

            if (rd_en) begin
                s1_valid <= 1'b1;
            end else if (out_load) begin
                s1_valid <= 1'b0;
            end

            // Output register only changes when empty or when its beat is taken.
            if (out_load) begin
                out_data  <= rd_data;
                out_valid <= 1'b1;
                out_last  <= s1_last;
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            if (out_fire && out_last) begin
                rd_done <= 1'b0;
            end
        end
    end

endmodule
